// File: rtl/csr_regfile.sv
`default_nettype none
// ============================================================================
// Module   : csr_regfile
// Brief    : RV32I machine-mode CSR file with 64-bit cycle/instret counters,
//            combinational write-first read port and illegal-address flag.
// Revision : 1.0 - initial release
// ============================================================================
module csr_regfile #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MHARTID     = 32'h0000_0000,
    parameter logic        CNT_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_read_addr,
    output logic [31:0] csr_read_data,
    output logic        csr_read_ill,
    input  logic        csr_write_en,
    input  logic [11:0] csr_write_addr,
    input  logic [31:0] csr_write_data,
    input  logic        instr_retire
);

    localparam logic [11:0] c_MSTATUS   = 12'h300;
    localparam logic [11:0] c_MIE       = 12'h304;
    localparam logic [11:0] c_MTVEC     = 12'h305;
    localparam logic [11:0] c_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_MEPC      = 12'h341;
    localparam logic [11:0] c_MCAUSE    = 12'h342;
    localparam logic [11:0] c_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_CYCLE     = 12'hC00;
    localparam logic [11:0] c_CYCLEH    = 12'hC80;
    localparam logic [11:0] c_INSTRET   = 12'hC02;
    localparam logic [11:0] c_INSTRETH  = 12'hC82;
    localparam logic [11:0] c_MHARTID   = 12'hF14;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic [31:0] w_rd_reg;
    logic        w_rd_valid;
    logic        w_rd_writable;
    logic        w_wr_ok;
    logic        w_bypass;

    // Decode of the read address: stored value, legality, writability.
    always_comb begin
        w_rd_reg      = 32'h0;
        w_rd_valid    = 1'b1;
        w_rd_writable = 1'b1;
        case (csr_read_addr)
            c_MSTATUS:   w_rd_reg = {24'h0, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000};
            c_MIE:       w_rd_reg = r_mie;
            c_MTVEC:     w_rd_reg = r_mtvec;
            c_MSCRATCH:  w_rd_reg = r_mscratch;
            c_MEPC:      w_rd_reg = r_mepc;
            c_MCAUSE:    w_rd_reg = r_mcause;
            c_MCYCLE:    w_rd_reg = r_mcycle[31:0];
            c_MCYCLEH:   w_rd_reg = r_mcycle[63:32];
            c_MINSTRET:  w_rd_reg = r_minstret[31:0];
            c_MINSTRETH: w_rd_reg = r_minstret[63:32];
            c_CYCLE: begin
                w_rd_reg      = r_mcycle[31:0];
                w_rd_writable = 1'b0;
            end
            c_CYCLEH: begin
                w_rd_reg      = r_mcycle[63:32];
                w_rd_writable = 1'b0;
            end
            c_INSTRET: begin
                w_rd_reg      = r_minstret[31:0];
                w_rd_writable = 1'b0;
            end
            c_INSTRETH: begin
                w_rd_reg      = r_minstret[63:32];
                w_rd_writable = 1'b0;
            end
            c_MHARTID: begin
                w_rd_reg      = MHARTID;
                w_rd_writable = 1'b0;
            end
            default: begin
                w_rd_valid    = 1'b0;
                w_rd_writable = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_wr_ok = 1'b0;
        case (csr_write_addr)
            c_MSTATUS, c_MIE, c_MTVEC, c_MSCRATCH, c_MEPC, c_MCAUSE,
            c_MCYCLE, c_MCYCLEH, c_MINSTRET, c_MINSTRETH: w_wr_ok = 1'b1;
            default:                                      w_wr_ok = 1'b0;
        endcase
    end

    // Write-first bypass returns the raw WB value, before field masking.
    assign w_bypass      = csr_write_en && w_rd_writable && (csr_write_addr == csr_read_addr);
    assign csr_read_data = w_bypass ? csr_write_data : w_rd_reg;
    assign csr_read_ill  = ~w_rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'h0;
            r_mtvec        <= MTVEC_RESET;
            r_mscratch     <= 32'h0;
            r_mepc         <= 32'h0;
            r_mcause       <= 32'h0;
        end else if (csr_write_en && w_wr_ok) begin
            case (csr_write_addr)
                c_MSTATUS: begin
                    r_mstatus_mie  <= csr_write_data[3];
                    r_mstatus_mpie <= csr_write_data[7];
                end
                c_MIE:      r_mie      <= csr_write_data;
                c_MTVEC:    r_mtvec    <= {csr_write_data[31:2], 1'b0, csr_write_data[0]};
                c_MSCRATCH: r_mscratch <= csr_write_data;
                c_MEPC:     r_mepc     <= {csr_write_data[31:2], 2'b00};
                c_MCAUSE:   r_mcause   <= csr_write_data;
                default:    ;
            endcase
        end
    end

    // A write to either half suppresses that counter's increment for the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
        end else begin
            if (csr_write_en && csr_write_addr == c_MCYCLE)
                r_mcycle[31:0] <= csr_write_data;
            else if (csr_write_en && csr_write_addr == c_MCYCLEH)
                r_mcycle[63:32] <= csr_write_data;
            else if (CNT_EN)
                r_mcycle <= r_mcycle + 64'd1;

            if (csr_write_en && csr_write_addr == c_MINSTRET)
                r_minstret[31:0] <= csr_write_data;
            else if (csr_write_en && csr_write_addr == c_MINSTRETH)
                r_minstret[63:32] <= csr_write_data;
            else if (CNT_EN && instr_retire)
                r_minstret <= r_minstret + 64'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_regfile
// Brief    : Directed self-checking bench for csr_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_regfile;

    logic        clk;
    logic        rst;
    logic [11:0] csr_read_addr;
    logic [31:0] csr_read_data;
    logic        csr_read_ill;
    logic        csr_write_en;
    logic [11:0] csr_write_addr;
    logic [31:0] csr_write_data;
    logic        instr_retire;

    int n_vec;
    int n_err;

    csr_regfile #(
        .MTVEC_RESET (32'h0000_0100),
        .MHARTID     (32'h0000_0007),
        .CNT_EN      (1'b1)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .csr_read_addr  (csr_read_addr),
        .csr_read_data  (csr_read_data),
        .csr_read_ill   (csr_read_ill),
        .csr_write_en   (csr_write_en),
        .csr_write_addr (csr_write_addr),
        .csr_write_data (csr_write_data),
        .instr_retire   (instr_retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Set the read address, let the combinational path settle, compare data.
    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_read_addr = addr;
        #1;
        check(tag, csr_read_data, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_write_en   = 1'b1;
        csr_write_addr = addr;
        csr_write_data = data;
    endtask

    logic [7:0] ret_pat;

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        csr_read_addr  = 12'h305;
        csr_write_en   = 1'b0;
        csr_write_addr = 12'h0;
        csr_write_data = 32'h0;
        instr_retire   = 1'b0;
        ret_pat        = 8'b1011_0101;

        // T1 reset
        tick();
        tick();
        rst = 1'b0;
        rd("rst_mtvec", 12'h305, 32'h0000_0100);
        check("rst_ill", {31'h0, csr_read_ill}, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcycle", 12'hB00, 32'h0);

        // T2 write / bypass / mepc mask
        wr(12'h341, 32'h0000_1237);
        rd("mepc_bypass", 12'h341, 32'h0000_1237);
        tick();
        csr_write_en = 1'b0;
        rd("mepc_masked", 12'h341, 32'h0000_1234);

        wr(12'h305, 32'hFFFF_FFFF);
        tick();
        csr_write_en = 1'b0;
        rd("mtvec_masked", 12'h305, 32'hFFFF_FFFD);

        wr(12'h340, 32'hDEAD_BEEF);
        tick();
        csr_write_en = 1'b0;
        rd("mscratch", 12'h340, 32'hDEAD_BEEF);

        // T3 counter carry into the high half
        rd("mcycleh_pre", 12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        csr_write_en = 1'b0;
        rd("mcycle_write_wins", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_hold", 12'hB80, 32'h0);
        tick();
        rd("mcycle_wrap_lo", 12'hB00, 32'h0);
        rd("mcycleh_carry", 12'hB80, 32'h1);
        rd("cycleh_alias", 12'hC80, 32'h1);

        // T4 instret: 5 retirements in 8 cycles, then a read-only alias write
        for (int i = 0; i < 8; i++) begin
            instr_retire = ret_pat[i];
            tick();
        end
        instr_retire = 1'b0;
        rd("minstret", 12'hB02, 32'h5);
        rd("instret_alias", 12'hC02, 32'h5);
        rd("minstreth", 12'hB82, 32'h0);
        wr(12'hC02, 32'h7);
        rd("instret_no_bypass", 12'hC02, 32'h5);
        tick();
        csr_write_en = 1'b0;
        rd("minstret_ro_ignored", 12'hB02, 32'h5);

        // T5 illegal address and read-only mhartid
        rd("illegal_data", 12'h7C0, 32'h0);
        check("illegal_ill", {31'h0, csr_read_ill}, 32'h1);
        wr(12'hF14, 32'h5);
        rd("mhartid_no_bypass", 12'hF14, 32'h7);
        tick();
        csr_write_en = 1'b0;
        rd("mhartid", 12'hF14, 32'h7);
        check("mhartid_ill", {31'h0, csr_read_ill}, 32'h0);

        // T6 mstatus mask, then reset with counters running
        wr(12'h300, 32'hFFFF_FFFF);
        tick();
        csr_write_en = 1'b0;
        rd("mstatus_mask", 12'h300, 32'h0000_0088);
        rst          = 1'b1;
        instr_retire = 1'b1;
        tick();
        rst          = 1'b0;
        instr_retire = 1'b0;
        rd("rst2_mcycle", 12'hB00, 32'h0);
        rd("rst2_mcycleh", 12'hB80, 32'h0);
        rd("rst2_minstret", 12'hB02, 32'h0);
        rd("rst2_mstatus", 12'h300, 32'h0);
        rd("rst2_mtvec", 12'h305, 32'h0000_0100);
        rd("rst2_mscratch", 12'h340, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            rd($sformatf("resume_mcycle_%0d", k), 12'hB00, 32'(k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
